axi_lite_guard: RTL and testbench
=================================

Name: axi_lite_guard

Overview:
- AXI-lite protection stage between the shell's AXI-lite master and a user-partition register slave.
- Presents a fully AXI-compliant slave port upstream and allows at most one outstanding read and one outstanding write.
- Accepts one-cycle response pulses from the downstream slave (rvalid/bvalid not held).
- If the downstream slave never answers, a SLVERR response is synthesised after a timeout, so the host never hangs.

Parameters:
- ADDR_WIDTH, 16, AXI-lite address width.
- DATA_WIDTH, 32, AXI-lite data width; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, response timeout in cycles; 0 disables the timeout.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on a read timeout.

Ports:
- s_axi_aclk in 1: clock for all logic.
- s_axi_areset in 1: synchronous, active-high reset.
- s_araddr/s_arvalid/s_arready: in ADDR_WIDTH / in 1 / out 1. Upstream read-address channel.
- s_rdata/s_rresp/s_rvalid/s_rready: out DATA_WIDTH / out 2 / out 1 / in 1. Upstream read-data channel.
- s_awaddr/s_awvalid/s_awready: in ADDR_WIDTH / in 1 / out 1. Upstream write-address channel.
- s_wdata/s_wstrb/s_wvalid/s_wready: in DATA_WIDTH / in DATA_WIDTH/8 / in 1 / out 1. Upstream write-data channel.
- s_bresp/s_bvalid/s_bready: out 2 / out 1 / in 1. Upstream write-response channel.
- m_* mirror of all five channels, opposite directions, same widths: downstream port.
- err_rd_timeout out 1: one-cycle pulse when a read times out.
- err_wr_timeout out 1: one-cycle pulse when a write times out.
- err_sticky out 2: bit0 = read timeout seen, bit1 = write timeout seen; cleared only by reset.
- stray_cnt out 8: count of downstream responses dropped; saturates at 255.

Behaviour:
- Reset values: all s_*valid, m_*valid, s_*ready, err_*, and stray_cnt are 0; data/resp registers are 0.
- Reset mid-transaction abandons the transaction silently; no response is issued.
- m_rready and m_bready are tied to 1 out of reset; the downstream is never backpressured.
- Read FSM, IDLE -> RD_REQ -> RD_RESP -> IDLE:
  - IDLE: s_arready=1. On s_arvalid, capture araddr (cycle 0) and go to RD_REQ.
  - RD_REQ: m_arvalid=1 from cycle 1, held until m_arvalid&m_arready, then dropped. The timer counts cycles 1..T.
  - m_rvalid is accepted in RD_REQ even in the same cycle as, or before, m_arready. Capture rdata/rresp and enter RD_RESP next cycle.
  - Timeout: if no m_rvalid by the end of cycle T, drop m_arvalid. Load s_rdata=TIMEOUT_RDATA and s_rresp=2'b10, pulse err_rd_timeout, set err_sticky[0], and enter RD_RESP.
  - If m_rvalid and timeout expiry occur in the same cycle, the real response wins.
  - RD_RESP: s_rvalid=1 with data stable until s_rready, then IDLE. s_arready=0 throughout.
  - Latency: a downstream answer sampled at cycle k gives s_rvalid at k+1. With a zero-wait downstream (arready=1, rvalid one cycle after arvalid), s_rvalid rises at cycle 3.
- Write FSM, W_IDLE -> W_REQ -> W_RESP -> W_IDLE:
  - W_IDLE: AW and W are captured independently. s_awready=1 until AW is held; s_wready=1 until W is held. Each may arrive first, or both together.
  - Once both are held, enter W_REQ. m_awvalid and m_wvalid assert together next cycle. Each drops independently on its own handshake. The timer starts.
  - m_bvalid is accepted in W_REQ. Capture bresp and enter W_RESP.
  - Timeout: drop any still-pending m_awvalid/m_wvalid, set s_bresp=2'b10, pulse err_wr_timeout, set err_sticky[1].
  - W_RESP: s_bvalid held until s_bready.
- Reads and writes proceed concurrently and independently.
- Stray responses: m_rvalid outside RD_REQ, or m_bvalid outside W_REQ, is dropped and increments stray_cnt. If both occur in the same cycle, stray_cnt increments by 2, saturating.
- TIMEOUT_CYCLES=0: the timer never expires; an FSM may wait forever.
- Timer width is clog2(TIMEOUT_CYCLES+1). The timer is reloaded to 0 on every request capture.

Test Plan:
- Zero-wait downstream (arready=1, one-cycle rvalid pulse at cycle 2, rdata=32'h1234_5678, rresp=0) -> s_rvalid at cycle 3 with 32'h1234_5678 and OKAY. Hold s_rready=0 for 5 cycles -> data stable, s_arready=0.
- AW at cycle 0, W at cycle 4 (addr 16'h4, data 32'hA5A5_0001) -> m_awvalid and m_wvalid both rise at cycle 6. bvalid pulse -> s_bvalid with OKAY.
- Silent downstream, TIMEOUT_CYCLES=16, read -> err_rd_timeout pulses once. s_rvalid with 32'hDEAD_BEEF and resp 2'b10 at cycle 17. err_sticky=2'b01.
- After the timeout, inject a late m_rvalid -> stray_cnt=1 and no upstream response. A following read completes normally.
- m_rvalid arrives exactly at cycle T=16 -> normal data returned, no error pulse.
- Reset asserted in RD_REQ and W_REQ -> all valids 0 on the next cycle; the next read and write succeed.

Source files
------------

// File: rtl/axi_lite_guard_if.sv
// AXI-lite bus bundle (five channels) shared by the guard's upstream and downstream ports.
interface axi_lite_guard_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_guard.sv
// AXI-lite protection stage: one outstanding read and write, tolerates pulsed downstream
// responses, and synthesises SLVERR when the downstream slave never answers.
module axi_lite_guard #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_areset,
    axi_lite_guard_if.slave        s_axi,
    axi_lite_guard_if.master       m_axi,
    output logic                   err_rd_timeout,
    output logic                   err_wr_timeout,
    output logic [1:0]             err_sticky,
    output logic [7:0]             stray_cnt
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;

    rd_state_t               rd_state;
    wr_state_t               wr_state;
    logic [TW-1:0]           rd_timer;
    logic [TW-1:0]           wr_timer;

    logic                    ar_ready_q;
    logic                    m_arvalid_q;
    logic [ADDR_WIDTH-1:0]   m_araddr_q;
    logic                    s_rvalid_q;
    logic [DATA_WIDTH-1:0]   s_rdata_q;
    logic [1:0]              s_rresp_q;
    logic                    sticky_rd;

    logic                    aw_ready_q;
    logic                    w_ready_q;
    logic                    aw_held;
    logic                    w_held;
    logic                    m_awvalid_q;
    logic                    m_wvalid_q;
    logic [ADDR_WIDTH-1:0]   m_awaddr_q;
    logic [DATA_WIDTH-1:0]   m_wdata_q;
    logic [DATA_WIDTH/8-1:0] m_wstrb_q;
    logic                    s_bvalid_q;
    logic [1:0]              s_bresp_q;
    logic                    sticky_wr;

    logic                    rd_stray;
    logic                    wr_stray;

    function automatic logic timer_expired(input logic [TW-1:0] t);
        return (TIMEOUT_CYCLES != 0) && (t == T_LAST);
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign s_axi.arready = ar_ready_q;
    assign s_axi.rvalid  = s_rvalid_q;
    assign s_axi.rdata   = s_rdata_q;
    assign s_axi.rresp   = s_rresp_q;
    assign s_axi.awready = aw_ready_q;
    assign s_axi.wready  = w_ready_q;
    assign s_axi.bvalid  = s_bvalid_q;
    assign s_axi.bresp   = s_bresp_q;

    assign m_axi.araddr  = m_araddr_q;
    assign m_axi.arvalid = m_arvalid_q;
    assign m_axi.rready  = 1'b1;
    assign m_axi.awaddr  = m_awaddr_q;
    assign m_axi.awvalid = m_awvalid_q;
    assign m_axi.wdata   = m_wdata_q;
    assign m_axi.wstrb   = m_wstrb_q;
    assign m_axi.wvalid  = m_wvalid_q;
    assign m_axi.bready  = 1'b1;

    assign err_sticky = {sticky_wr, sticky_rd};

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rd_state       <= RD_IDLE;
            rd_timer       <= '0;
            ar_ready_q     <= 1'b0;
            m_arvalid_q    <= 1'b0;
            m_araddr_q     <= '0;
            s_rvalid_q     <= 1'b0;
            s_rdata_q      <= '0;
            s_rresp_q      <= 2'b00;
            err_rd_timeout <= 1'b0;
            sticky_rd      <= 1'b0;
        end else begin
            err_rd_timeout <= 1'b0;
            case (rd_state)
                RD_IDLE: begin
                    if (s_axi.arvalid && ar_ready_q) begin
                        m_araddr_q  <= s_axi.araddr;
                        ar_ready_q  <= 1'b0;
                        m_arvalid_q <= 1'b1;
                        rd_timer    <= '0;
                        rd_state    <= RD_REQ;
                    end else begin
                        ar_ready_q <= 1'b1;
                    end
                end
                RD_REQ: begin
                    rd_timer <= rd_timer + 1'b1;
                    if (m_arvalid_q && m_axi.arready) begin
                        m_arvalid_q <= 1'b0;
                    end
                    // A real answer beats a timeout that expires in the same cycle.
                    if (m_axi.rvalid) begin
                        s_rdata_q   <= m_axi.rdata;
                        s_rresp_q   <= m_axi.rresp;
                        s_rvalid_q  <= 1'b1;
                        m_arvalid_q <= 1'b0;
                        rd_state    <= RD_RESP;
                    end else if (timer_expired(rd_timer)) begin
                        s_rdata_q      <= TIMEOUT_RDATA;
                        s_rresp_q      <= 2'b10;
                        s_rvalid_q     <= 1'b1;
                        m_arvalid_q    <= 1'b0;
                        err_rd_timeout <= 1'b1;
                        sticky_rd      <= 1'b1;
                        rd_state       <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (s_axi.rready) begin
                        s_rvalid_q <= 1'b0;
                        ar_ready_q <= 1'b1;
                        rd_state   <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wr_state       <= W_IDLE;
            wr_timer       <= '0;
            aw_ready_q     <= 1'b0;
            w_ready_q      <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            m_awvalid_q    <= 1'b0;
            m_wvalid_q     <= 1'b0;
            m_awaddr_q     <= '0;
            m_wdata_q      <= '0;
            m_wstrb_q      <= '0;
            s_bvalid_q     <= 1'b0;
            s_bresp_q      <= 2'b00;
            err_wr_timeout <= 1'b0;
            sticky_wr      <= 1'b0;
        end else begin
            err_wr_timeout <= 1'b0;
            case (wr_state)
                W_IDLE: begin
                    // AW and W are collected independently; dispatch only once both are held.
                    if (s_axi.awvalid && aw_ready_q) begin
                        m_awaddr_q <= s_axi.awaddr;
                        aw_ready_q <= 1'b0;
                        aw_held    <= 1'b1;
                    end else if (!aw_held) begin
                        aw_ready_q <= 1'b1;
                    end
                    if (s_axi.wvalid && w_ready_q) begin
                        m_wdata_q <= s_axi.wdata;
                        m_wstrb_q <= s_axi.wstrb;
                        w_ready_q <= 1'b0;
                        w_held    <= 1'b1;
                    end else if (!w_held) begin
                        w_ready_q <= 1'b1;
                    end
                    if (aw_held && w_held) begin
                        m_awvalid_q <= 1'b1;
                        m_wvalid_q  <= 1'b1;
                        wr_timer    <= '0;
                        wr_state    <= W_REQ;
                    end
                end
                W_REQ: begin
                    wr_timer <= wr_timer + 1'b1;
                    if (m_awvalid_q && m_axi.awready) begin
                        m_awvalid_q <= 1'b0;
                    end
                    if (m_wvalid_q && m_axi.wready) begin
                        m_wvalid_q <= 1'b0;
                    end
                    if (m_axi.bvalid) begin
                        s_bresp_q   <= m_axi.bresp;
                        s_bvalid_q  <= 1'b1;
                        m_awvalid_q <= 1'b0;
                        m_wvalid_q  <= 1'b0;
                        wr_state    <= W_RESP;
                    end else if (timer_expired(wr_timer)) begin
                        s_bresp_q      <= 2'b10;
                        s_bvalid_q     <= 1'b1;
                        m_awvalid_q    <= 1'b0;
                        m_wvalid_q     <= 1'b0;
                        err_wr_timeout <= 1'b1;
                        sticky_wr      <= 1'b1;
                        wr_state       <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        s_bvalid_q <= 1'b0;
                        aw_held    <= 1'b0;
                        w_held     <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        wr_state   <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Responses arriving when nothing is outstanding are dropped and counted.
    assign rd_stray = m_axi.rvalid && (rd_state != RD_REQ);
    assign wr_stray = m_axi.bvalid && (wr_state != W_REQ);

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            stray_cnt <= 8'd0;
        end else begin
            stray_cnt <= sat_add(stray_cnt, {1'b0, rd_stray} + {1'b0, wr_stray});
        end
    end

endmodule

// File: tb/tb_axi_lite_guard.sv
// Directed bench for axi_lite_guard: stimulus pushes expected responses, a negedge monitor
// pops and compares them whenever the upstream read or write response handshakes.
module tb_axi_lite_guard;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    axi_lite_guard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi ();
    axi_lite_guard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

    logic       err_rd_timeout;
    logic       err_wr_timeout;
    logic [1:0] err_sticky;
    logic [7:0] stray_cnt;

    axi_lite_guard #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(32'hDEAD_BEEF)
    ) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst), .s_axi(s_axi), .m_axi(m_axi),
        .err_rd_timeout(err_rd_timeout), .err_wr_timeout(err_wr_timeout),
        .err_sticky(err_sticky), .stray_cnt(stray_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          issue;
        int          lat;
    } rexp_t;

    typedef struct {
        logic [1:0] resp;
        int         issue;
        int         lat;
    } wexp_t;

    rexp_t rq[$];
    wexp_t bq[$];
    int total = 0;
    int bad = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int r_rise = 0;
    int w_rise = 0;
    bit r_seen = 0;
    bit w_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        rexp_t re;
        wexp_t we;
        if (rst) begin
            r_seen = 0;
            w_seen = 0;
        end else begin
            if (err_rd_timeout) rd_pulses++;
            if (err_wr_timeout) wr_pulses++;
            if (s_axi.rvalid && !r_seen) begin
                r_seen = 1;
                r_rise = cyc;
            end
            if (s_axi.bvalid && !w_seen) begin
                w_seen = 1;
                w_rise = cyc;
            end
            if (s_axi.rvalid && s_axi.rready) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got rdata %h with no read outstanding", s_axi.rdata);
                end else begin
                    re = rq.pop_front();
                    chk("rd_data", s_axi.rdata, re.data);
                    chk("rd_resp", 32'(s_axi.rresp), 32'(re.resp));
                    if (re.lat >= 0) chk("rd_latency", r_rise - re.issue, re.lat);
                end
                r_seen = 0;
            end
            if (s_axi.bvalid && s_axi.bready) begin
                if (bq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: got bresp %h with no write outstanding", s_axi.bresp);
                end else begin
                    we = bq.pop_front();
                    chk("wr_resp", 32'(s_axi.bresp), 32'(we.resp));
                    if (we.lat >= 0) chk("wr_latency", w_rise - we.issue, we.lat);
                end
                w_seen = 0;
            end
        end
    end

    task automatic wait_ar();
        int n = 0;
        while (!s_axi.arready && n < 50) begin tick(); n++; end
        if (!s_axi.arready) chk("wait_arready", 0, 1);
    endtask

    task automatic wait_aww();
        int n = 0;
        while (!(s_axi.awready && s_axi.wready) && n < 50) begin tick(); n++; end
        if (!(s_axi.awready && s_axi.wready)) chk("wait_aw_w_ready", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() + bq.size()) != 0 && n < 100) begin tick(); n++; end
        chk("queues_empty", rq.size() + bq.size(), 0);
    endtask

    task automatic zw_read(input logic [15:0] a, input logic [31:0] d, input logic [1:0] r);
        m_axi.arready = 1'b1;
        wait_ar();
        s_axi.arvalid = 1'b1;
        s_axi.araddr  = a;
        rq.push_back('{d, r, cyc, 3});
        tick();
        s_axi.arvalid = 1'b0;
        tick();
        m_axi.rvalid = 1'b1;
        m_axi.rdata  = d;
        m_axi.rresp  = r;
        tick();
        m_axi.rvalid = 1'b0;
        drain();
    endtask

    task automatic zw_write(input logic [15:0] a, input logic [31:0] d, input logic [1:0] r);
        m_axi.awready = 1'b1;
        m_axi.wready  = 1'b1;
        wait_aww();
        s_axi.awvalid = 1'b1;
        s_axi.awaddr  = a;
        s_axi.wvalid  = 1'b1;
        s_axi.wdata   = d;
        s_axi.wstrb   = 4'hF;
        bq.push_back('{r, cyc, 4});
        tick();
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        tick();
        chk("zw_m_awaddr", 32'(m_axi.awaddr), 32'(a));
        chk("zw_m_wdata", m_axi.wdata, d);
        tick();
        m_axi.bvalid = 1'b1;
        m_axi.bresp  = r;
        tick();
        m_axi.bvalid = 1'b0;
        drain();
    endtask

    initial begin
        int p0;
        s_axi.araddr = '0; s_axi.arvalid = 0; s_axi.rready = 1;
        s_axi.awaddr = '0; s_axi.awvalid = 0; s_axi.wdata = '0; s_axi.wstrb = '0;
        s_axi.wvalid = 0; s_axi.bready = 1;
        m_axi.arready = 0; m_axi.rdata = '0; m_axi.rresp = 0; m_axi.rvalid = 0;
        m_axi.awready = 0; m_axi.wready = 0; m_axi.bresp = 0; m_axi.bvalid = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_s_arready", 32'(s_axi.arready), 0);
        chk("rst_s_rvalid", 32'(s_axi.rvalid), 0);
        chk("rst_s_awready", 32'(s_axi.awready), 0);
        chk("rst_s_wready", 32'(s_axi.wready), 0);
        chk("rst_s_bvalid", 32'(s_axi.bvalid), 0);
        chk("rst_m_valids", 32'({m_axi.arvalid, m_axi.awvalid, m_axi.wvalid}), 0);
        chk("rst_s_rdata", s_axi.rdata, 0);
        chk("rst_err", 32'({err_rd_timeout, err_wr_timeout, err_sticky}), 0);
        chk("rst_stray", 32'(stray_cnt), 0);
        rst = 1'b0;
        tick();
        tick();

        // Zero-wait read with upstream backpressure
        m_axi.arready = 1'b1;
        s_axi.rready  = 1'b0;
        wait_ar();
        s_axi.arvalid = 1'b1;
        s_axi.araddr  = 16'h0010;
        rq.push_back('{32'h1234_5678, 2'b00, cyc, 3});
        tick();
        s_axi.arvalid = 1'b0;
        chk("t1_m_arvalid", 32'(m_axi.arvalid), 1);
        chk("t1_m_araddr", 32'(m_axi.araddr), 32'h10);
        chk("t1_s_arready", 32'(s_axi.arready), 0);
        tick();
        chk("t1_m_arvalid_drop", 32'(m_axi.arvalid), 0);
        m_axi.rvalid = 1'b1;
        m_axi.rdata  = 32'h1234_5678;
        m_axi.rresp  = 2'b00;
        tick();
        m_axi.rvalid = 1'b0;
        m_axi.rdata  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("t1_hold_rvalid", 32'(s_axi.rvalid), 1);
            chk("t1_hold_rdata", s_axi.rdata, 32'h1234_5678);
            chk("t1_hold_arready", 32'(s_axi.arready), 0);
            tick();
        end
        s_axi.rready = 1'b1;
        drain();

        // Write: AW at cycle 0, W at cycle 4
        m_axi.awready = 1'b1;
        m_axi.wready  = 1'b1;
        wait_aww();
        s_axi.awvalid = 1'b1;
        s_axi.awaddr  = 16'h0004;
        bq.push_back('{2'b00, cyc, 8});
        tick();
        s_axi.awvalid = 1'b0;
        chk("t2_s_awready", 32'(s_axi.awready), 0);
        chk("t2_s_wready", 32'(s_axi.wready), 1);
        repeat (3) tick();
        s_axi.wvalid = 1'b1;
        s_axi.wdata  = 32'hA5A5_0001;
        s_axi.wstrb  = 4'hF;
        tick();
        s_axi.wvalid = 1'b0;
        chk("t2_c5_m_valids", 32'({m_axi.awvalid, m_axi.wvalid}), 0);
        chk("t2_c5_s_wready", 32'(s_axi.wready), 0);
        tick();
        chk("t2_c6_m_valids", 32'({m_axi.awvalid, m_axi.wvalid}), 32'b11);
        chk("t2_m_awaddr", 32'(m_axi.awaddr), 32'h4);
        chk("t2_m_wdata", m_axi.wdata, 32'hA5A5_0001);
        chk("t2_m_wstrb", 32'(m_axi.wstrb), 32'hF);
        tick();
        chk("t2_c7_m_valids", 32'({m_axi.awvalid, m_axi.wvalid}), 0);
        m_axi.bvalid = 1'b1;
        m_axi.bresp  = 2'b00;
        tick();
        m_axi.bvalid = 1'b0;
        chk("t2_s_bvalid", 32'(s_axi.bvalid), 1);
        drain();

        // Silent downstream: read timeout
        m_axi.arready = 1'b0;
        p0 = rd_pulses;
        wait_ar();
        s_axi.arvalid = 1'b1;
        s_axi.araddr  = 16'h0020;
        rq.push_back('{32'hDEAD_BEEF, 2'b10, cyc, 17});
        tick();
        s_axi.arvalid = 1'b0;
        repeat (15) tick();
        chk("t3_c16_m_arvalid", 32'(m_axi.arvalid), 1);
        chk("t3_c16_s_rvalid", 32'(s_axi.rvalid), 0);
        tick();
        chk("t3_err_rd_timeout", 32'(err_rd_timeout), 1);
        chk("t3_m_arvalid_drop", 32'(m_axi.arvalid), 0);
        chk("t3_sticky", 32'(err_sticky), 32'b01);
        tick();
        chk("t3_pulse_count", rd_pulses - p0, 1);
        chk("t3_err_rd_low", 32'(err_rd_timeout), 0);
        drain();

        // Late downstream response after the timeout is dropped
        m_axi.rvalid = 1'b1;
        m_axi.rdata  = 32'h0000_0BAD;
        tick();
        m_axi.rvalid = 1'b0;
        tick();
        chk("t4_stray_cnt", 32'(stray_cnt), 1);
        chk("t4_no_rvalid", 32'(s_axi.rvalid), 0);
        zw_read(16'h0030, 32'hCAFE_0002, 2'b00);

        // Response arriving in the last cycle before expiry wins
        m_axi.arready = 1'b1;
        p0 = rd_pulses;
        wait_ar();
        s_axi.arvalid = 1'b1;
        s_axi.araddr  = 16'h0040;
        rq.push_back('{32'h5A5A_0016, 2'b00, cyc, 17});
        tick();
        s_axi.arvalid = 1'b0;
        repeat (15) tick();
        m_axi.rvalid = 1'b1;
        m_axi.rdata  = 32'h5A5A_0016;
        m_axi.rresp  = 2'b00;
        tick();
        m_axi.rvalid = 1'b0;
        tick();
        chk("t5_no_pulse", rd_pulses - p0, 0);
        drain();

        // Write timeout with both m_awvalid and m_wvalid pending
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b0;
        p0 = wr_pulses;
        wait_aww();
        s_axi.awvalid = 1'b1;
        s_axi.awaddr  = 16'h0008;
        s_axi.wvalid  = 1'b1;
        s_axi.wdata   = 32'h0BAD_F00D;
        bq.push_back('{2'b10, cyc, 18});
        tick();
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        repeat (16) tick();
        chk("t6_c17_s_bvalid", 32'(s_axi.bvalid), 0);
        chk("t6_c17_m_valids", 32'({m_axi.awvalid, m_axi.wvalid}), 32'b11);
        tick();
        chk("t6_err_wr_timeout", 32'(err_wr_timeout), 1);
        chk("t6_m_valids_drop", 32'({m_axi.awvalid, m_axi.wvalid}), 0);
        chk("t6_sticky", 32'(err_sticky), 32'b11);
        tick();
        chk("t6_pulse_count", wr_pulses - p0, 1);
        drain();

        // Simultaneous stray read and write responses, then saturation
        m_axi.rvalid = 1'b1;
        m_axi.bvalid = 1'b1;
        tick();
        tick();
        chk("t7_stray_double", 32'(stray_cnt), 5);
        repeat (130) tick();
        m_axi.rvalid = 1'b0;
        m_axi.bvalid = 1'b0;
        tick();
        chk("t7_stray_sat", 32'(stray_cnt), 255);

        // Reset while both FSMs are waiting downstream
        m_axi.arready = 1'b0;
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b0;
        wait_ar();
        wait_aww();
        s_axi.arvalid = 1'b1;
        s_axi.awvalid = 1'b1;
        s_axi.wvalid  = 1'b1;
        tick();
        s_axi.arvalid = 1'b0;
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        tick();
        chk("t8_pre_m_valids", 32'({m_axi.arvalid, m_axi.awvalid, m_axi.wvalid}), 32'b111);
        rst = 1'b1;
        tick();
        chk("t8_m_valids", 32'({m_axi.arvalid, m_axi.awvalid, m_axi.wvalid}), 0);
        chk("t8_s_valids", 32'({s_axi.rvalid, s_axi.bvalid}), 0);
        chk("t8_sticky", 32'(err_sticky), 0);
        chk("t8_stray", 32'(stray_cnt), 0);
        rst = 1'b0;
        tick();
        zw_read(16'h0050, 32'h0000_FACE, 2'b00);
        zw_write(16'h0054, 32'h1357_9BDF, 2'b00);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
